// File: rtl/alu_arbiter.sv
// alu_arbiter: NUM_REQ requesters share one ALU, with one operation in flight at a time.
// The optional macro ALU_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
// Without the macro, the lowest requesting index wins (fixed priority).
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]  req_op,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_last_grant;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [3:0]       r_op;
    logic [31:0]      r_result;

    logic             w_any_req;
    logic             w_found;
    logic [IDX_W-1:0] w_winner;
    int unsigned      w_rr_idx;
    logic [31:0]      w_sel_a;
    logic [31:0]      w_sel_b;
    logic [3:0]       w_sel_op;
    logic             w_owner_rsp_ready;
    logic [31:0]      w_alu_out;

    assign w_any_req = |req_valid;

    // Pick the winning requester among the currently valid requests.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_rr_idx = 0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_rr_idx = 32'(r_last_grant) + k;
            if (w_rr_idx >= NUM_REQ) begin
                w_rr_idx = w_rr_idx - NUM_REQ;
            end
            if (!w_found && req_valid[w_rr_idx]) begin
                w_winner = IDX_W'(w_rr_idx);
                w_found  = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_winner = IDX_W'(i);
                w_found  = 1'b1;
            end
        end
`endif
    end

    // Select the winner's operands and op, and the owner's rsp_ready.
    always_comb begin
        w_sel_a           = '0;
        w_sel_b           = '0;
        w_sel_op          = '0;
        w_owner_rsp_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_sel_a  = req_a[i*32 +: 32];
                w_sel_b  = req_b[i*32 +: 32];
                w_sel_op = req_op[i*4 +: 4];
            end
            if (r_owner == IDX_W'(i)) begin
                w_owner_rsp_ready = rsp_ready[i];
            end
        end
    end

    // The single shared ALU, fed only from the latched operands.
    always_comb begin
        w_alu_out = '0;
        case (r_op)
            4'd0:    w_alu_out = r_a + r_b;
            4'd1:    w_alu_out = r_a << r_b[4:0];
            4'd2,
            4'd3:    w_alu_out = {31'd0, (r_a < r_b)};
            4'd4:    w_alu_out = r_a ^ r_b;
            4'd5:    w_alu_out = r_a >> r_b[4:0];
            4'd6:    w_alu_out = 32'($signed(r_a) >>> r_b[4:0]);
            4'd7:    w_alu_out = r_a | r_b;
            4'd8:    w_alu_out = r_a & r_b;
            4'd9:    w_alu_out = r_a - r_b;
            4'd10:   w_alu_out = r_b;
            default: w_alu_out = '0;
        endcase
    end

    // Next-state logic and the same-cycle grant.
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req && !reset) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (w_winner == IDX_W'(i));
                    end
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC:  w_next_state = S_RESP;
            S_RESP: begin
                if (w_owner_rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Response outputs are decoded from registered state only.
    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (r_state == S_RESP) && (r_owner == IDX_W'(i));
        end
        rsp_data = (r_state == S_RESP) ? r_result : 32'd0;
        busy     = (r_state != S_IDLE);
    end

    // State, request latch and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_result     <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_any_req) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_op         <= w_sel_op;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu_out;
            end
        end
    end

    // Structural sanity: at most one grant, and the pointer stays in range.
    a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
    a_last_in_range: assert property (@(posedge clk) disable iff (reset) 32'(r_last_grant) < NUM_REQ);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vector table, corner sequences and randomized model check.
module tb_alu_arbiter;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*4-1:0]  req_op;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_data;
    logic            busy;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [14];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drive(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[4*r +: 4]  = op;
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a << b[4:0];
            4'd2, 4'd3: return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a >> b[4:0];
            4'd6: begin
                ext = {{32{a[31]}}, a};
                ext = ext >> b[4:0];
                return ext[31:0];
            end
            4'd7:  return a | b;
            4'd8:  return a & b;
            4'd9:  return a - b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    // One complete transaction on requester r with rsp_ready high; checks every latency step.
    task automatic run_vec(input int r, input vec_t v, input int idx);
        logic [N-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        req_valid = oh;
        drive(r, v.op, v.a, v.b);
        rsp_ready = '1;
        #2;
        chk($sformatf("vec%0d ready c0", idx), 32'(req_ready), 32'(oh));
        step();
        req_valid = '0;
        #2;
        chk($sformatf("vec%0d busy c1", idx), 32'(busy), 32'd1);
        chk($sformatf("vec%0d rsp_valid c1", idx), 32'(rsp_valid), 32'd0);
        step();
        #2;
        chk($sformatf("vec%0d rsp_valid c2", idx), 32'(rsp_valid), 32'(oh));
        chk($sformatf("vec%0d rsp_data c2", idx), rsp_data, v.exp);
        step();
        #2;
        chk($sformatf("vec%0d busy c3", idx), 32'(busy), 32'd0);
        chk($sformatf("vec%0d rsp_data c3", idx), rsp_data, 32'd0);
    endtask

    logic [N-1:0] e_ready;
    logic [N-1:0] e_rv;
    logic [31:0]  e_data;
    logic         m_active;
    int           m_age;
    int           m_owner;
    int           m_last;
    logic [31:0]  m_res;
    int           g;
    int           exp_g;
    logic [N-1:0] oh2;

    initial begin
        tbl[0]  = '{4'd0,  32'd5,          32'd7,          32'd12};
        tbl[1]  = '{4'd1,  32'd3,          32'd2,          32'd12};
        tbl[2]  = '{4'd2,  32'hFFFF_FFFF,  32'd1,          32'd0};
        tbl[3]  = '{4'd3,  32'd1,          32'hFFFF_FFFF,  32'd1};
        tbl[4]  = '{4'd4,  32'hF0F0_0000,  32'h0FF0_0000,  32'hFF00_0000};
        tbl[5]  = '{4'd5,  32'h8000_0000,  32'd4,          32'h0800_0000};
        tbl[6]  = '{4'd6,  32'h8000_0000,  32'd4,          32'hF800_0000};
        tbl[7]  = '{4'd7,  32'd1,          32'd2,          32'd3};
        tbl[8]  = '{4'd8,  32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00};
        tbl[9]  = '{4'd9,  32'd10,         32'd3,          32'd7};
        tbl[10] = '{4'd9,  32'd0,          32'd1,          32'hFFFF_FFFF};
        tbl[11] = '{4'd10, 32'd1,          32'hDEAD_BEEF,  32'hDEAD_BEEF};
        tbl[12] = '{4'd13, 32'h0000_FFFF,  32'd1,          32'd0};
        tbl[13] = '{4'd15, 32'h1234_5678,  32'h1,          32'd0};

        reset = 1'b1;
        clear_inputs();
        do_reset();
        #2;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);

        // Vector table, alternating requesters.
        for (int i = 0; i < 14; i++) begin
            run_vec(i % N, tbl[i], i);
        end

        // Contention: both requesters hold sub 10-3 continuously.
        do_reset();
        req_valid = '1;
        drive(0, 4'd9, 32'd10, 32'd3);
        drive(1, 4'd9, 32'd10, 32'd3);
        rsp_ready = '1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_g = k % 2;
`else
            exp_g = 0;
`endif
            oh2 = '0;
            oh2[exp_g] = 1'b1;
            #2;
            chk($sformatf("contend grant%0d", k), 32'(req_ready), 32'(oh2));
            step();
            step();
            #2;
            chk($sformatf("contend rsp_valid%0d", k), 32'(rsp_valid), 32'(oh2));
            chk($sformatf("contend data%0d", k), rsp_data, 32'd7);
            step();
        end

        // Backpressure on requester 1 while requester 0 waits.
        do_reset();
        req_valid = 2'b10;
        drive(1, 4'd6, 32'h8000_0000, 32'd4);
        rsp_ready = 2'b00;
        #2;
        chk("bp accept1", 32'(req_ready), 32'b10);
        step();
        req_valid = 2'b01;
        drive(0, 4'd0, 32'd1, 32'd1);
        drive(1, 4'd0, 32'd0, 32'd0);
        rsp_ready = 2'b01;
        #2;
        chk("bp exec ready", 32'(req_ready), 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            #2;
            chk($sformatf("bp hold valid%0d", k), 32'(rsp_valid), 32'b10);
            chk($sformatf("bp hold data%0d", k), rsp_data, 32'hF800_0000);
            chk($sformatf("bp hold ready%0d", k), 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 2'b11;
        #2;
        chk("bp release valid", 32'(rsp_valid), 32'b10);
        chk("bp release ready", 32'(req_ready), 32'd0);
        step();
        #2;
        chk("bp req0 accept", 32'(req_ready), 32'b01);
        step();
        req_valid = '0;
        step();
        #2;
        chk("bp req0 data", rsp_data, 32'd2);
        step();

        // Reset during EXEC discards the operation.
        do_reset();
        req_valid = 2'b01;
        drive(0, 4'd7, 32'd1, 32'd2);
        rsp_ready = '1;
        #2;
        chk("rst accept", 32'(req_ready), 32'b01);
        step();
        req_valid = '0;
        reset = 1'b1;
        #2;
        chk("rst exec busy", 32'(busy), 32'd1);
        chk("rst exec no grant", 32'(req_ready), 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("rst after busy%0d", k), 32'(busy), 32'd0);
            chk($sformatf("rst after valid%0d", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("rst after data%0d", k), rsp_data, 32'd0);
            step();
        end

        // Operands changing after acceptance must not affect the result.
        do_reset();
        req_valid = 2'b01;
        drive(0, 4'd1, 32'd3, 32'd2);
        rsp_ready = '1;
        #2;
        chk("opchg accept", 32'(req_ready), 32'b01);
        step();
        req_valid = '0;
        drive(0, 4'd0, 32'd0, 32'd0);
        step();
        #2;
        chk("opchg data", rsp_data, 32'd12);
        step();

        // Randomized run against the transaction-level model.
        do_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_owner  = 0;
        m_last   = N - 1;
        m_res    = '0;
        for (int c = 0; c < 1500; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_op[4*i +: 4]  = 4'($urandom_range(0, 15));
                req_a[32*i +: 32] = $urandom;
                if (req_op[4*i +: 4] == 4'd1 || req_op[4*i +: 4] == 4'd5 || req_op[4*i +: 4] == 4'd6)
                    req_b[32*i +: 32] = 32'($urandom_range(0, 31));
                else
                    req_b[32*i +: 32] = $urandom;
            end
            #2;
            e_ready = '0;
            e_rv    = '0;
            e_data  = '0;
            g       = -1;
            if (!m_active) begin
                g = pick(req_valid, m_last);
                if (g >= 0 && !reset) e_ready[g] = 1'b1;
            end else if (m_age >= 2) begin
                e_rv[m_owner] = 1'b1;
                e_data        = m_res;
            end
            chk($sformatf("rand%0d req_ready", c), 32'(req_ready), 32'(e_ready));
            chk($sformatf("rand%0d rsp_valid", c), 32'(rsp_valid), 32'(e_rv));
            chk($sformatf("rand%0d rsp_data", c), rsp_data, e_data);
            chk($sformatf("rand%0d busy", c), 32'(busy), 32'(m_active));
            if (reset) begin
                m_active = 1'b0;
                m_last   = N - 1;
            end else if (!m_active) begin
                if (g >= 0) begin
                    m_active = 1'b1;
                    m_age    = 1;
                    m_owner  = g;
                    m_last   = g;
                    m_res    = ref_alu(req_op[4*g +: 4], req_a[32*g +: 32], req_b[32*g +: 32]);
                end
            end else if (m_age >= 2) begin
                if (rsp_ready[m_owner]) m_active = 1'b0;
            end else begin
                m_age = m_age + 1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one ALU; legal range 2..4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  NUM_REQ  per-requester operation request.
REQ-005 req_ready  output  NUM_REQ  per-requester acceptance; at most one bit high per cycle.
REQ-006 req_a, req_b  input  NUM_REQ*32 each  packed operands, requester i at bits [32i+31:32i].
REQ-007 req_op  input  NUM_REQ*4  packed ALU op codes, requester i at bits [4i+3:4i].
REQ-008 rsp_valid  output  NUM_REQ  result available for requester i.
REQ-009 rsp_ready  input  NUM_REQ  requester i consumes result.
REQ-010 rsp_data  output  32  result of the operation owned by the requester whose rsp_valid is high.
REQ-011 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 Block SHALL instantiate exactly one ALU and share it among requesters; one operation outstanding at a time.
REQ-013 ALU op codes SHALL be passed unchanged: 0 add, 1 sll, 2/3 slt (unsigned compare), 4 xor, 5 srl, 6 sra, 7 or, 8 and, 9 sub, 10 pass B, 11-15 result 0.
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid high, winner chosen combinationally, req_ready[winner]=1 same cycle; operands, op and owner index latched; next state EXEC. No request: stay IDLE, req_ready=0.
REQ-016 EXEC: ALU driven from latched operands; output registered into result register; next state RESP; req_ready=0.
REQ-017 RESP: rsp_valid[owner]=1, rsp_data=result register, held stable until rsp_ready[owner]=1; on that cycle next state IDLE. rsp_ready of non-owners ignored.
REQ-018 Latency: request accepted at cycle N -> rsp_valid high at cycle N+2; minimum 3 cycles between acceptances.
REQ-019 req_valid arriving in EXEC or RESP SHALL not be accepted until FSM returns to IDLE; requester must hold request and operands.
REQ-020 Pointer last_grant SHALL update to owner index on each acceptance.
REQ-021 rsp_data SHALL be 0 whenever no rsp_valid bit is high.
REQ-022 Operands changing after acceptance SHALL not affect the in-flight result.

Reset
REQ-023 reset SHALL force IDLE, clear req_ready, rsp_valid, busy, rsp_data and result register to 0, and set last_grant to NUM_REQ-1.
REQ-024 reset in EXEC or RESP SHALL discard the in-flight operation; no rsp_valid is produced for it.
REQ-025 reset dominates all other inputs in the same cycle.

Configuration
REQ-026 Macro ALU_ARB_ROUND_ROBIN_EN defined: winner is first requesting index strictly after last_grant, wrapping at NUM_REQ-1 -> 0.
REQ-027 Macro ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest requesting index wins; last_grant still maintained but unused.

Verification
REQ-028 Single request: req0 a=5, b=7, op=0 at cycle 0, rsp_ready0=1 -> req_ready0=1 cycle 0, rsp_valid0=1 with rsp_data=12 at cycle 2, IDLE at cycle 3.
REQ-029 Contention, round-robin build: req0 and req1 held valid continuously, op=9 a=10 b=3 both -> grants alternate 0,1,0,1 every 3 cycles, each rsp_data=7; fixed-priority build -> requester 0 granted every time.
REQ-030 Backpressure: req1 op=6 a=0x80000000 b=4, rsp_ready1=0 for 5 cycles -> rsp_valid1 and rsp_data=0xF8000000 held stable all 5 cycles; req0 valid meanwhile not accepted until cycle after rsp_ready1=1.
REQ-031 Reset mid-op: accept req0 op=7 a=1 b=2, assert reset in EXEC -> next cycle IDLE, busy=0, rsp_valid=0; no response ever issued for that op.
REQ-032 Illegal op: req0 op=13 a=0xFFFF b=1 -> rsp_data=0 at cycle 2; operands changed to a=0 after acceptance do not alter result of op=1 a=3 b=2 (rsp_data=12).
